hack_alu_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational Hack ALU. It takes the same six-bit Hack control word, operand width set by `WIDTH`, and adds carry and overflow flags, a pass-through tag, and a two-stage pipeline with valid/ready handshakes on both sides. It sits between the CPU decode stage and writeback, so the ALU path can be retimed without changing the instruction encoding.

---
 rtl/hack_alu_pkg.sv | 25 ++
 rtl/hack_alu_core.sv | 27 ++
 rtl/hack_alu_pipe.sv | 119 +++++++++++
 tb/tb_hack_alu_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_alu_pkg.sv
// Shared definitions for the pipelined Hack ALU: control-word bit positions
// and the reference control encodings.
package hack_alu_pkg;

  typedef logic [5:0] alu_ctl_t;

  // Bit positions inside the control word {zx, zy, nx, ny, f, no}
  localparam int unsigned CTL_ZX = 5;
  localparam int unsigned CTL_ZY = 4;
  localparam int unsigned CTL_NX = 3;
  localparam int unsigned CTL_NY = 2;
  localparam int unsigned CTL_F  = 1;
  localparam int unsigned CTL_NO = 0;

  // Reference encodings
  localparam alu_ctl_t ALU_ZERO = 6'b110010;
  localparam alu_ctl_t ALU_ONE  = 6'b111111;
  localparam alu_ctl_t ALU_NEG1 = 6'b111010;
  localparam alu_ctl_t ALU_ADD  = 6'b000010;
  localparam alu_ctl_t ALU_AND  = 6'b000000;
  localparam alu_ctl_t ALU_SUB  = 6'b001011;
  localparam alu_ctl_t ALU_NOTX = 6'b010101;
  localparam alu_ctl_t ALU_INC  = 6'b011111;

endpackage

// File: rtl/hack_alu_core.sv
// Combinational Hack ALU datapath on preprocessed operands: add/and select,
// optional output inversion, carry and signed-overflow flags of the adder.
module hack_alu_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             cf,
  output logic             vf
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;

  // Function select, inversion and adder flags (flags only meaningful when f)
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    r   = f ? sum[WIDTH-1:0] : (a & b);
    out = no ? ~r : r;
    cf  = f & sum[WIDTH];
    vf  = f & (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready handshakes, pass-through tag,
// flush, and carry/overflow flags. S1 holds preprocessed operands, S2 holds
// the result and flags that drive the outputs directly.
module hack_alu_pipe
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cf,
  output logic             vf,
  output logic [TAG_W-1:0] out_tag
);

  alu_ctl_t         c;
  logic             adv1, adv2;
  logic [WIDTH-1:0] a_pre, b_pre;

  logic             s1_valid, s1_f, s1_no;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;

  logic [WIDTH-1:0] core_out;
  logic             core_cf, core_vf;

  assign c = alu_ctl_t'(ctl);

  // Backpressure chain: a stage advances when it is empty or its successor advances
  always_comb begin
    adv2     = !s2_valid || out_ready;
    adv1     = !s1_valid || adv2;
    in_ready = adv1 && !flush;
  end

  // Operand preprocessing: zero then invert
  always_comb begin
    a_pre = c[CTL_ZX] ? '0 : x;
    if (c[CTL_NX]) a_pre = ~a_pre;
    b_pre = c[CTL_ZY] ? '0 : y;
    if (c[CTL_NY]) b_pre = ~b_pre;
  end

  // Stage 1 register: preprocessed operands, function bits and tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_f     <= 1'b0;
      s1_no    <= 1'b0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a_pre;
        s1_b   <= b_pre;
        s1_f   <= c[CTL_F];
        s1_no  <= c[CTL_NO];
        s1_tag <= in_tag;
      end
    end
  end

  hack_alu_core #(.WIDTH(WIDTH)) u_core (
    .a   (s1_a),
    .b   (s1_b),
    .f   (s1_f),
    .no  (s1_no),
    .out (core_out),
    .cf  (core_cf),
    .vf  (core_vf)
  );

  // Stage 2 register: result and flags; data only loads with a valid op so
  // the outputs keep their last values while the pipe is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out      <= '0;
      zr       <= 1'b1;
      ng       <= 1'b0;
      cf       <= 1'b0;
      vf       <= 1'b0;
      out_tag  <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out     <= core_out;
        zr      <= (core_out == '0);
        ng      <= core_out[WIDTH-1];
        cf      <= core_cf;
        vf      <= core_vf;
        out_tag <= s1_tag;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Self-checking bench for hack_alu_pipe: table-driven vectors through a
// scoreboard queue, plus directed backpressure, flush, reset and width cases.
module tb_hack_alu_pipe;
  import hack_alu_pkg::*;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  ctl;
    logic [3:0]  tag;
    logic [15:0] out;
    logic        zr, ng, cf, vf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x, y, out;
  logic [5:0]  ctl;
  logic [3:0]  in_tag, out_tag;
  logic        zr, ng, cf, vf;

  logic        w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready;
  logic [7:0]  w8_x, w8_y, w8_out;
  logic [5:0]  w8_ctl;
  logic [0:0]  w8_in_tag, w8_out_tag;
  logic        w8_zr, w8_ng, w8_cf, w8_vf;

  logic        ready_cmd = 1'b1, rand_bp = 1'b0, rnd_bit = 1'b1;
  assign out_ready = rand_bp ? rnd_bit : ready_cmd;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  vec_t sb[$];
  vec_t tbl[11];

  always #5 clk = ~clk;

  hack_alu_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctl(ctl), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .cf(cf), .vf(vf), .out_tag(out_tag)
  );

  hack_alu_pipe #(.WIDTH(8), .TAG_W(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .x(w8_x), .y(w8_y), .ctl(w8_ctl), .in_tag(w8_in_tag), .out_valid(w8_out_valid),
    .out_ready(w8_out_ready), .out(w8_out), .zr(w8_zr), .ng(w8_ng), .cf(w8_cf), .vf(w8_vf),
    .out_tag(w8_out_tag)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t tv(input logic [15:0] vx, input logic [15:0] vy, input logic [5:0] vc,
                              input logic [3:0] vt, input logic [15:0] vo,
                              input logic vzr, input logic vng, input logic vcf, input logic vvf);
    vec_t v;
    v.x = vx; v.y = vy; v.ctl = vc; v.tag = vt; v.out = vo;
    v.zr = vzr; v.ng = vng; v.cf = vcf; v.vf = vvf;
    return v;
  endfunction

  // Reference model using integer arithmetic and signed range for overflow
  function automatic vec_t model(input logic [15:0] vx, input logic [15:0] vy,
                                 input logic [5:0] vc, input logic [3:0] vt);
    int unsigned a, b, s, r, o;
    int sa, sb_i, ss;
    vec_t v;
    a = vc[5] ? 0 : int'(vx);
    if (vc[3]) a = 32'hFFFF - a;
    b = vc[4] ? 0 : int'(vy);
    if (vc[2]) b = 32'hFFFF - b;
    s = a + b;
    r = vc[1] ? (s % 65536) : (a & b);
    o = vc[0] ? (32'hFFFF - r) : r;
    sa   = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb_i = (b >= 32768) ? int'(b) - 65536 : int'(b);
    ss   = sa + sb_i;
    v = tv(vx, vy, vc, vt, o[15:0], o == 0, o >= 32768,
           vc[1] && (s > 32'hFFFF), vc[1] && (ss > 32767 || ss < -32768));
    return v;
  endfunction

  // Drive one operation and push its expectation once it is accepted
  task automatic send(input vec_t v);
    bit acc = 0;
    in_valid = 1'b1; x = v.x; y = v.y; ctl = v.ctl; in_tag = v.tag;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(v);
        acc = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  // Random backpressure source
  initial forever begin
    @(posedge clk); #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Output monitor: compare each consumed result against the scoreboard head
  initial forever begin
    vec_t e;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {28'd0, out_tag}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        pops++;
        chk($sformatf("out[%0d]", pops), out, e.out);
        chk($sformatf("tag[%0d]", pops), out_tag, e.tag);
        chk($sformatf("flags[%0d]", pops), {zr, ng, cf, vf}, {e.zr, e.ng, e.cf, e.vf});
      end
    end
    if (flush) sb.delete();
  end

  initial begin
    int t0, t1;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    x = '0; y = '0; ctl = '0; in_tag = '0;
    w8_in_valid = 1'b0; w8_x = '0; w8_y = '0; w8_ctl = '0; w8_in_tag = '0; w8_out_ready = 1'b1;

    tbl[0]  = tv(16'd5,      16'd3,      ALU_SUB,  4'h1, 16'h0002, 0, 0, 0, 0);
    tbl[1]  = tv(16'h7FFF,   16'h0001,   ALU_ADD,  4'h2, 16'h8000, 0, 1, 0, 1);
    tbl[2]  = tv(16'hFFFF,   16'h0001,   ALU_ADD,  4'h3, 16'h0000, 1, 0, 1, 0);
    tbl[3]  = tv(16'h00F0,   16'h0F0F,   ALU_ZERO, 4'h4, 16'h0000, 1, 0, 0, 0);
    tbl[4]  = tv(16'h00F0,   16'h0F0F,   ALU_ONE,  4'h5, 16'h0001, 0, 0, 1, 0);
    tbl[5]  = tv(16'h00F0,   16'h0F0F,   ALU_NEG1, 4'h6, 16'hFFFF, 0, 1, 0, 0);
    tbl[6]  = tv(16'h00F0,   16'h0F0F,   ALU_ADD,  4'h7, 16'h0FFF, 0, 0, 0, 0);
    tbl[7]  = tv(16'h00F0,   16'h0F0F,   ALU_AND,  4'h8, 16'h0000, 1, 0, 0, 0);
    tbl[8]  = tv(16'h00F0,   16'h0F0F,   ALU_SUB,  4'h9, 16'hF1E1, 0, 1, 1, 0);
    tbl[9]  = tv(16'h00F0,   16'h0F0F,   ALU_NOTX, 4'hA, 16'hFF0F, 0, 1, 0, 0);
    tbl[10] = tv(16'h00F0,   16'h0F0F,   ALU_INC,  4'hB, 16'h00F1, 0, 0, 1, 0);

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_flags", {zr, ng, cf, vf}, 4'b1000);
    chk("rst_tag", out_tag, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Table vectors back-to-back; the sweep must accept one op per cycle
    for (int i = 0; i < 3; i++) send(tbl[i]);
    t0 = $time;
    for (int i = 3; i < 11; i++) send(tbl[i]);
    t1 = $time;
    chk("sweep_cycles", (t1 - t0) / 10, 8);
    wait_drain();
    chk("sweep_pops", pops, 11);

    // Backpressure: two accepted, third held off until the sink is ready
    ready_cmd = 1'b0;
    send(model(16'h1111, 16'h2222, ALU_ADD, 4'h1));
    send(model(16'h3333, 16'h0001, ALU_SUB, 4'h2));
    in_valid = 1'b1; x = 16'h0042; y = 16'h0007; ctl = ALU_AND; in_tag = 4'h3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_tag", out_tag, 4'h1);
      chk("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    ready_cmd = 1'b1;
    send(model(16'h0042, 16'h0007, ALU_AND, 4'h3));
    wait_drain();

    // Flush with both stages full: nothing stale may emerge
    ready_cmd = 1'b0;
    send(model(16'h0100, 16'h0200, ALU_ADD, 4'hC));
    send(model(16'h0300, 16'h0400, ALU_ADD, 4'hD));
    in_valid = 1'b1; x = 16'h0005; y = 16'h0005; ctl = ALU_ADD; in_tag = 4'hE; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_sb_empty", sb.size(), 0);
    ready_cmd = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(model(16'h0009, 16'h0004, ALU_SUB, 4'hF));
    wait_drain();

    // Random operands and control words under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++)
      send(model(16'($urandom), 16'($urandom), 6'($urandom), 4'($urandom)));
    rand_bp = 1'b0;
    wait_drain();

    // Asynchronous reset mid-stream
    send(model(16'h0010, 16'h0020, ALU_ADD, 4'h5));
    send(model(16'h0030, 16'h0040, ALU_ADD, 4'h6));
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_zr", zr, 1);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_tag", out_tag, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_out_valid", out_valid, 0);

    // WIDTH=8 wrap-around with carry and overflow
    w8_in_valid = 1'b1; w8_x = 8'h80; w8_y = 8'h80; w8_ctl = ALU_ADD; w8_in_tag = 1'b1;
    @(negedge clk);
    chk("w8_in_ready", w8_in_ready, 1);
    @(posedge clk); #1;
    w8_in_valid = 1'b0;
    for (int c = 0; c < 10 && !w8_out_valid; c++) @(negedge clk);
    chk("w8_out_valid", w8_out_valid, 1);
    chk("w8_out", w8_out, 8'h00);
    chk("w8_flags", {w8_zr, w8_ng, w8_cf, w8_vf}, 4'b1011);
    chk("w8_tag", w8_out_tag, 1);

    @(posedge clk); #1;
    chk("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
